// File: rtl/spiker_reader.sv
// Streams a snapshot of the input-spike registers into the SNN core, one word
// per beat, repeating the frame for a programmed number of timesteps.
module spiker_reader #(
   parameter int WIDTH    = 32,
   parameter int N_SPIKES = 784,
   parameter int N_REG    = 25,
   parameter int STEP_W   = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   test_mode_i,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [STEP_W-1:0]      n_steps_i,
   input  logic [N_REG*WIDTH-1:0] spikes_i,
   output logic [WIDTH-1:0]       spike_data_o,
   output logic                   spike_valid_o,
   input  logic                   spike_ready_i,
   output logic                   frame_last_o,
   output logic                   run_last_o,
   output logic [STEP_W-1:0]      step_idx_o,
   output logic                   busy_o,
   output logic                   done_o
);

   localparam int CW  = (N_REG > 1) ? $clog2(N_REG) : 1;
   localparam int TOT = N_REG * WIDTH;

   // Bits beyond the last real spike are padding in the top register word.
   function automatic logic [TOT-1:0] spike_mask();
      logic [TOT-1:0] m;
      for (int i = 0; i < TOT; i++) m[i] = (i < N_SPIKES);
      return m;
   endfunction
   localparam logic [TOT-1:0] MASK = spike_mask();

   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

   state_t                        state;
   logic [N_REG-1:0][WIDTH-1:0]   buf_q;
   logic [CW-1:0]                 word_cnt;
   logic [STEP_W-1:0]             step_cnt;
   logic [STEP_W-1:0]             steps_q;
   logic                          in_stream;
   logic                          frame_last;
   logic                          run_last;
   logic                          hs;
   logic                          unused_test;

   assign unused_test   = test_mode_i;
   assign in_stream     = (state == STREAM);
   assign frame_last    = in_stream && (word_cnt == CW'(N_REG - 1));
   assign run_last      = frame_last && (step_cnt == steps_q - STEP_W'(1));
   assign hs            = in_stream && spike_ready_i;

   assign spike_valid_o = in_stream;
   assign busy_o        = in_stream;
   assign spike_data_o  = in_stream ? buf_q[word_cnt] : '0;
   assign frame_last_o  = frame_last;
   assign run_last_o    = run_last;
   assign step_idx_o    = in_stream ? step_cnt : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         buf_q    <= '0;
         word_cnt <= '0;
         step_cnt <= '0;
         steps_q  <= '0;
         done_o   <= 1'b0;
      end else if (abort_i) begin
         state    <= IDLE;
         word_cnt <= '0;
         step_cnt <= '0;
         done_o   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_o <= 1'b0;
               if (start_i) begin
                  buf_q    <= spikes_i & MASK;
                  steps_q  <= n_steps_i;
                  word_cnt <= '0;
                  step_cnt <= '0;
                  state    <= (n_steps_i != '0) ? STREAM : DONE;
               end
            end
            STREAM: begin
               if (hs) begin
                  if (!frame_last) begin
                     word_cnt <= word_cnt + CW'(1);
                  end else begin
                     word_cnt <= '0;
                     if (run_last) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                     end else begin
                        step_cnt <= step_cnt + STEP_W'(1);
                     end
                  end
               end
            end
            DONE: begin
               // A zero-step run enters here with done_o low and spends one
               // extra cycle so the pulse lands two cycles after start.
               if (done_o) begin
                  done_o <= 1'b0;
                  state  <= IDLE;
               end else begin
                  done_o <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spiker_reader.sv
// Scoreboard bench for spiker_reader: expected beats are queued at start and
// popped on every handshake.
module tb_spiker_reader;

   localparam int WIDTH = 32, N_SPIKES = 784, N_REG = 25, STEP_W = 16;

   typedef struct packed {
      logic [WIDTH-1:0]  d;
      logic              fl;
      logic              rl;
      logic [STEP_W-1:0] st;
   } beat_t;

   logic                   clk_i = 0, rst_ni = 0, test_mode_i = 0;
   logic                   start_i = 0, abort_i = 0, spike_ready_i = 0;
   logic [STEP_W-1:0]      n_steps_i = '0;
   logic [N_REG*WIDTH-1:0] spikes_i = '0;
   logic [WIDTH-1:0]       spike_data_o;
   logic                   spike_valid_o, frame_last_o, run_last_o, busy_o, done_o;
   logic [STEP_W-1:0]      step_idx_o;

   int    checks = 0, failures = 0;
   beat_t q[$];

   spiker_reader #(.WIDTH(WIDTH), .N_SPIKES(N_SPIKES), .N_REG(N_REG), .STEP_W(STEP_W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i),
      .start_i(start_i), .abort_i(abort_i), .n_steps_i(n_steps_i),
      .spikes_i(spikes_i), .spike_data_o(spike_data_o), .spike_valid_o(spike_valid_o),
      .spike_ready_i(spike_ready_i), .frame_last_o(frame_last_o), .run_last_o(run_last_o),
      .step_idx_o(step_idx_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [WIDTH-1:0] exp_word(input logic [N_REG*WIDTH-1:0] sp, input int k);
      logic [WIDTH-1:0] w;
      for (int b = 0; b < WIDTH; b++) w[b] = (k*WIDTH + b < N_SPIKES) ? sp[k*WIDTH + b] : 1'b0;
      return w;
   endfunction

   task automatic push_run(input int steps);
      beat_t e;
      for (int s = 0; s < steps; s++)
         for (int k = 0; k < N_REG; k++) begin
            e.d  = exp_word(spikes_i, k);
            e.fl = (k == N_REG-1);
            e.rl = (k == N_REG-1) && (s == steps-1);
            e.st = STEP_W'(s);
            q.push_back(e);
         end
   endtask

   task automatic load_pattern();
      for (int k = 0; k < N_REG; k++) spikes_i[k*WIDTH +: WIDTH] = 32'hA000_0000 + k;
      spikes_i[24*WIDTH+16 +: 16] = 16'hFFFF;
   endtask

   // Common streaming driver; every comparison is made inline here.
   task automatic run_stream(input string nm, input int steps, input bit rnd, input bit mutate);
      beat_t e, prev;
      bit    have_prev = 0, rdy;
      int    cyc = 0;
      q.delete();
      push_run(steps);
      n_steps_i = STEP_W'(steps);
      start_i = 1;
      @(negedge clk_i);
      start_i = 0;
      checks++;
      if (busy_o !== 1'b1 || spike_valid_o !== 1'b1) begin
         failures++; $display("FAIL %s_first_beat busy=%b valid=%b required 1/1", nm, busy_o, spike_valid_o);
      end
      while (q.size() > 0 && cyc < 4000) begin
         checks++;
         if (spike_valid_o !== 1'b1) begin
            failures++; $display("FAIL %s_valid cyc=%0d valid=%b required 1", nm, cyc, spike_valid_o);
         end
         if (have_prev) begin
            checks++;
            if (spike_data_o !== prev.d || frame_last_o !== prev.fl || run_last_o !== prev.rl || step_idx_o !== prev.st) begin
               failures++; $display("FAIL %s_stable cyc=%0d got %h/%b/%b/%0d required %h/%b/%b/%0d", nm, cyc,
                  spike_data_o, frame_last_o, run_last_o, step_idx_o, prev.d, prev.fl, prev.rl, prev.st);
            end
         end
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         spike_ready_i = rdy;
         if (rdy) begin
            e = q.pop_front();
            checks++;
            if (spike_data_o !== e.d || frame_last_o !== e.fl || run_last_o !== e.rl || step_idx_o !== e.st) begin
               failures++; $display("FAIL %s_beat cyc=%0d got %h/%b/%b/%0d required %h/%b/%b/%0d", nm, cyc,
                  spike_data_o, frame_last_o, run_last_o, step_idx_o, e.d, e.fl, e.rl, e.st);
            end
            have_prev = 0;
         end else begin
            prev = '{d: spike_data_o, fl: frame_last_o, rl: run_last_o, st: step_idx_o};
            have_prev = 1;
         end
         if (mutate && cyc == 30) begin
            spikes_i  = ~spikes_i;
            n_steps_i = 16'd1;
         end
         start_i = mutate && (cyc == 40);
         @(negedge clk_i);
         start_i = 0;
         cyc++;
      end
      spike_ready_i = 0;
      checks++;
      if (q.size() != 0) begin
         failures++; $display("FAIL %s_timeout remaining=%0d required 0", nm, q.size());
      end
      if (!rnd) begin
         checks++;
         if (cyc != steps*N_REG) begin
            failures++; $display("FAIL %s_throughput cycles=%0d required %0d", nm, cyc, steps*N_REG);
         end
      end
      checks++;
      if (done_o !== 1'b1 || spike_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         failures++; $display("FAIL %s_done done=%b valid=%b busy=%b required 1/0/0", nm, done_o, spike_valid_o, busy_o);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         checks++;
         if (done_o !== 1'b0 || spike_valid_o !== 1'b0) begin
            failures++; $display("FAIL %s_after_done cyc=%0d done=%b valid=%b required 0/0", nm, i, done_o, spike_valid_o);
         end
      end
   endtask

   task automatic test_reset();
      rst_ni = 0;
      repeat (2) @(negedge clk_i);
      checks++;
      if ({spike_data_o, spike_valid_o, frame_last_o, run_last_o, step_idx_o, busy_o, done_o} !== '0) begin
         failures++; $display("FAIL reset_outputs data=%h valid=%b busy=%b done=%b required all 0", spike_data_o, spike_valid_o, busy_o, done_o);
      end
      rst_ni = 1;
      @(negedge clk_i);
   endtask

   task automatic test_basic();         run_stream("basic", 1, 0, 0); endtask
   task automatic test_multi_step();    run_stream("multi", 3, 0, 0); endtask
   task automatic test_backpressure();  run_stream("bp", 3, 1, 0); endtask
   task automatic test_snapshot();      run_stream("snap", 2, 1, 1); load_pattern(); endtask

   task automatic test_zero_steps();
      n_steps_i = '0;
      start_i = 1;
      @(negedge clk_i);
      start_i = 0;
      checks++;
      if (done_o !== 1'b0 || spike_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         failures++; $display("FAIL zero_cycle1 done=%b valid=%b busy=%b required 0/0/0", done_o, spike_valid_o, busy_o);
      end
      @(negedge clk_i);
      checks++;
      if (done_o !== 1'b1 || spike_valid_o !== 1'b0) begin
         failures++; $display("FAIL zero_cycle2 done=%b valid=%b required 1/0", done_o, spike_valid_o);
      end
      @(negedge clk_i);
      checks++;
      if (done_o !== 1'b0 || spike_valid_o !== 1'b0) begin
         failures++; $display("FAIL zero_cycle3 done=%b valid=%b required 0/0", done_o, spike_valid_o);
      end
   endtask

   task automatic test_abort();
      n_steps_i = 16'd3;
      start_i = 1;
      @(negedge clk_i);
      start_i = 0;
      spike_ready_i = 1;
      for (int i = 0; i < N_REG + 10; i++) @(negedge clk_i);
      checks++;
      if (spike_data_o !== exp_word(spikes_i, 10) || step_idx_o !== 16'd1 || spike_valid_o !== 1'b1) begin
         failures++; $display("FAIL abort_pos data=%h step=%0d valid=%b required %h/1/1", spike_data_o, step_idx_o, spike_valid_o, exp_word(spikes_i, 10));
      end
      abort_i = 1;
      @(negedge clk_i);
      abort_i = 0;
      spike_ready_i = 0;
      checks++;
      if (spike_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
         failures++; $display("FAIL abort_stop valid=%b busy=%b done=%b required 0/0/0", spike_valid_o, busy_o, done_o);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         checks++;
         if (done_o !== 1'b0 || spike_valid_o !== 1'b0) begin
            failures++; $display("FAIL abort_idle cyc=%0d done=%b valid=%b required 0/0", i, done_o, spike_valid_o);
         end
      end
      run_stream("post_abort", 1, 0, 0);
   endtask

   task automatic test_start_abort();
      n_steps_i = 16'd2;
      start_i = 1;
      abort_i = 1;
      @(negedge clk_i);
      start_i = 0;
      abort_i = 0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (spike_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            failures++; $display("FAIL start_abort cyc=%0d valid=%b busy=%b done=%b required 0/0/0", i, spike_valid_o, busy_o, done_o);
         end
         @(negedge clk_i);
      end
   endtask

   task automatic test_reset_mid();
      n_steps_i = 16'd2;
      start_i = 1;
      @(negedge clk_i);
      start_i = 0;
      spike_ready_i = 1;
      repeat (5) @(negedge clk_i);
      rst_ni = 0;
      #1;
      checks++;
      if ({spike_data_o, spike_valid_o, frame_last_o, run_last_o, step_idx_o, busy_o, done_o} !== '0) begin
         failures++; $display("FAIL reset_mid data=%h valid=%b busy=%b done=%b required all 0", spike_data_o, spike_valid_o, busy_o, done_o);
      end
      spike_ready_i = 0;
      @(negedge clk_i);
      rst_ni = 1;
      @(negedge clk_i);
   endtask

   initial begin
      load_pattern();
      test_reset();
      test_basic();
      test_multi_step();
      test_backpressure();
      test_snapshot();
      test_zero_steps();
      test_abort();
      test_start_abort();
      test_reset_mid();
      test_basic();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spiker_reader.md
Name: spiker_reader

Overview:
- Register-to-IP path of the spiker adapter: on a software start pulse, snapshots the input-spike registers, N_REG words of WIDTH bits.
- Streams the snapshot word-by-word into the SNN core over a valid/ready interface.
- Repeats the whole frame for a programmed number of timesteps, then signals completion back to the register file.
- Counterpart of the block that samples core results into the result registers.

Parameters:
- WIDTH, 32, bits per register word and per stream beat.
- N_SPIKES, 784, number of valid input spikes per frame.
- N_REG, 25, registers per frame; must equal ceil(N_SPIKES/WIDTH).
- STEP_W, 16, width of the timestep count.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- test_mode_i  in  1  DFT mode; no functional effect
- start_i  in  1  one-cycle start pulse from the register file
- abort_i  in  1  one-cycle abort pulse
- n_steps_i  in  STEP_W  timesteps to stream, sampled at start
- spikes_i  in  N_REG*WIDTH  flattened spike registers; word k = bits [(k+1)*WIDTH-1 -: WIDTH]
- spike_data_o  out  WIDTH  current beat data
- spike_valid_o  out  1  beat valid
- spike_ready_i  in  1  core accepts beat
- frame_last_o  out  1  current beat is the last word of a frame
- run_last_o  out  1  current beat is the last word of the last frame
- step_idx_o  out  STEP_W  index of the frame being streamed
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; state IDLE; snapshot buffer, word_cnt, step_cnt, steps_q all 0.
- States: IDLE, STREAM, DONE.

IDLE:
- busy_o=0, spike_valid_o=0.
- start_i=1 and abort_i=0 → snapshot spikes_i into the buffer.
  - Bits with global index >= N_SPIKES are forced to 0; with defaults, word 24 keeps bits [15:0] only.
  - Latch n_steps_i into steps_q; clear word_cnt and step_cnt.
- If n_steps_i != 0 → STREAM, else → DONE.
- busy_o rises the cycle after start_i.
- The first valid beat appears the cycle after start_i.

STREAM:
- busy_o=1, spike_valid_o=1.
- spike_data_o = buffer[word_cnt]; step_idx_o = step_cnt.
- frame_last_o = (word_cnt==N_REG-1).
- run_last_o = frame_last_o & (step_cnt==steps_q-1).
- Handshake occurs on spike_valid_o & spike_ready_i.
- Without a handshake, spike_data_o, frame_last_o, run_last_o and step_idx_o hold stable; valid is never withdrawn except by abort.
- On a handshake:
  - word_cnt < N_REG-1 → word_cnt++.
  - Else word_cnt=0, and:
    - run_last_o → DONE.
    - Otherwise step_cnt++, and the next frame starts back-to-back with no bubble.
- Throughput: one beat per cycle while spike_ready_i is held high.

DONE:
- done_o=1 for exactly one cycle; busy_o=0; spike_valid_o=0.
- Next state IDLE.
- Completion latency: done_o asserts the cycle after the final handshake.

Start, abort and stability rules:
- start_i outside IDLE is ignored.
- abort_i in any state → IDLE next cycle: valid drops, busy_o=0, no done_o pulse, counters cleared.
- abort_i and start_i in the same cycle: abort wins and no run starts.
- spikes_i and n_steps_i changes during STREAM have no effect; the snapshot is used.
- A start_i arriving in the DONE cycle is ignored.
- Total beats per run = N_REG * steps_q.
- steps_q = 2^STEP_W-1 is legal; counters do not wrap within a run.

Test Plan:
- Basic run: reset; spikes_i word k = 32'hA000_0000+k, upper 16 bits of word 24 set; n_steps=1; ready tied 1 → 25 beats on consecutive cycles starting the cycle after start_i.
  - Word 24 carries only its low 16 bits; frame_last_o and run_last_o both high on beat 24.
  - done_o pulses the cycle after beat 24.
- Multi-step: n_steps=3 → 75 beats, step_idx_o 0/1/2, frame_last_o on beats 24/49/74, run_last_o only on beat 74, one done_o.
- Backpressure: ready toggled pseudo-randomly → data/last/step_idx stable while valid&!ready; beat sequence identical to the ready-high case.
- Snapshot: rewrite spikes_i and n_steps_i mid-stream → output still matches the start-time values and beat count.
- Zero steps / ignored start: n_steps=0 → done_o the cycle after DONE is entered (two cycles after start_i), no valid beats.
  - start_i during STREAM → ignored, counts unchanged.
- Abort and reset: abort at beat 10 of step 1 → valid low next cycle, no done_o; a new start_i runs a full frame cleanly.
  - Simultaneous start+abort in IDLE → no run.
  - rst_ni asserted mid-stream → all outputs 0 immediately.
